bp_sched: RTL and testbench

BP_SCHED -- requirements
Module: bp_sched

---
 rtl/bp_pkg.sv | 17 +
 rtl/bp_conv_check.sv | 32 +++
 rtl/bp_sched.sv | 172 +++++++++++++++++
 tb/tb_bp_sched.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and constants for the belief-propagation run sequencer.
// State encoding, iteration counter width and default belief width.
package bp_pkg;

    localparam int ITER_W        = 8;
    localparam int BELIEF_W_DFLT = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_CHECK,
        S_STOP,
        S_DONE
    } state_t;

endpackage

// File: rtl/bp_conv_check.sv
// Combinational convergence test: every belief within DELTA_TH of its snapshot (unsigned |a-b|, no wrap).
// Zero latency; no flow control.
module bp_conv_check #(
    parameter int NUM_VARS = 4,
    parameter int BELIEF_W = 8,
    parameter int DELTA_TH = 2
) (
    input  logic [NUM_VARS*2*BELIEF_W-1:0] i_beliefs,
    input  logic [NUM_VARS*2*BELIEF_W-1:0] i_snapshot,
    output logic                           o_within
);

    localparam int                N  = NUM_VARS * 2;
    localparam logic [BELIEF_W:0] TH = (BELIEF_W + 1)'(DELTA_TH);

    logic [N-1:0] w_ok;

    for (genvar g = 0; g < N; g++) begin : g_cmp
        logic [BELIEF_W:0] w_a;
        logic [BELIEF_W:0] w_b;
        logic [BELIEF_W:0] w_diff;

        // Extra MSB keeps the subtraction from wrapping.
        assign w_a    = {1'b0, i_beliefs[g*BELIEF_W +: BELIEF_W]};
        assign w_b    = {1'b0, i_snapshot[g*BELIEF_W +: BELIEF_W]};
        assign w_diff = (w_a >= w_b) ? (w_a - w_b) : (w_b - w_a);
        assign w_ok[g] = (w_diff <= TH);
    end

    assign o_within = &w_ok;

endmodule

// File: rtl/bp_sched.sv
// bp_sched: BP run sequencer (INIT x2, RUN x ITER_CYCLES, CHECK), optional convergence stop under BP_SCHED_CONV_DETECT_EN.
// Latency start->first RUN 3 cycles, ITER_CYCLES+1 per iteration; no backpressure, start ignored while busy or in DONE.
module bp_sched
    import bp_pkg::*;
#(
    parameter int NUM_VARS    = 4,
    parameter int BELIEF_W    = BELIEF_W_DFLT,
    parameter int ITER_CYCLES = 16,
    parameter int DELTA_TH    = 2
) (
    input  logic                           CLK100MHZ,
    input  logic                           Reset_n,
    input  logic                           start,
    input  logic                           abort,
    input  logic [ITER_W-1:0]              max_iters,
    input  logic [NUM_VARS*2*BELIEF_W-1:0] beliefs,
    output logic                           var_init,
    output logic                           var_stop,
    output logic                           busy,
    output logic                           done,
    output logic                           converged,
    output logic [ITER_W-1:0]              iter_count
);

    localparam int                CYC_W    = (ITER_CYCLES > 1) ? $clog2(ITER_CYCLES) : 1;
    localparam logic [CYC_W-1:0]  CYC_LAST = CYC_W'(ITER_CYCLES - 1);

    state_t              r_state;
    logic [CYC_W-1:0]    r_cyc;
    logic                r_init_2nd;
    logic [ITER_W-1:0]   r_max_iters;
    logic [ITER_W-1:0]   r_iter_count;
    logic                r_converged;
    logic                r_var_init;
    logic                r_var_stop;
    logic                r_busy;
    logic                r_done;

    logic [ITER_W-1:0]   w_iter_next;
    logic                w_conv_now;

    // Saturating increment; unreachable with an 8-bit limit but kept as a guard.
    assign w_iter_next = (r_iter_count == {ITER_W{1'b1}}) ? r_iter_count
                                                          : r_iter_count + ITER_W'(1);

`ifdef BP_SCHED_CONV_DETECT_EN
    logic [NUM_VARS*2*BELIEF_W-1:0] r_snapshot;
    logic                           w_within;

    bp_conv_check #(
        .NUM_VARS (NUM_VARS),
        .BELIEF_W (BELIEF_W),
        .DELTA_TH (DELTA_TH)
    ) u_conv_check (
        .i_beliefs  (beliefs),
        .i_snapshot (r_snapshot),
        .o_within   (w_within)
    );

    // First CHECK compares against a cleared snapshot, so it never counts.
    assign w_conv_now = w_within && (r_iter_count != '0);

    always_ff @(posedge CLK100MHZ or negedge Reset_n) begin
        if (!Reset_n) begin
            r_snapshot <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_snapshot <= '0;
        end else if (r_state == S_CHECK) begin
            r_snapshot <= beliefs;
        end
    end
`else
    logic w_unused_beliefs;

    assign w_unused_beliefs = ^beliefs;
    assign w_conv_now       = 1'b0;
`endif

    always_ff @(posedge CLK100MHZ or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state      <= S_IDLE;
            r_cyc        <= '0;
            r_init_2nd   <= 1'b0;
            r_max_iters  <= '0;
            r_iter_count <= '0;
            r_converged  <= 1'b0;
            r_var_init   <= 1'b0;
            r_var_stop   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state      <= S_INIT;
                        r_max_iters  <= (max_iters == '0) ? ITER_W'(1) : max_iters;
                        r_iter_count <= '0;
                        r_converged  <= 1'b0;
                        r_cyc        <= '0;
                        r_init_2nd   <= 1'b0;
                        r_var_init   <= 1'b1;
                        r_busy       <= 1'b1;
                    end
                end
                S_INIT: begin
                    r_cyc <= '0;
                    if (abort) begin
                        r_state    <= S_STOP;
                        r_var_init <= 1'b0;
                        r_var_stop <= 1'b1;
                    end else if (r_init_2nd) begin
                        r_state    <= S_RUN;
                        r_var_init <= 1'b0;
                    end else begin
                        r_init_2nd <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        r_state    <= S_STOP;
                        r_var_stop <= 1'b1;
                    end else if (r_cyc == CYC_LAST) begin
                        r_state <= S_CHECK;
                    end else begin
                        r_cyc <= r_cyc + CYC_W'(1);
                    end
                end
                S_CHECK: begin
                    // Abort beats convergence and leaves iter_count untouched.
                    if (abort) begin
                        r_state    <= S_STOP;
                        r_var_stop <= 1'b1;
                    end else begin
                        r_iter_count <= w_iter_next;
                        if (w_conv_now) begin
                            r_state     <= S_STOP;
                            r_converged <= 1'b1;
                            r_var_stop  <= 1'b1;
                        end else if (w_iter_next == r_max_iters) begin
                            r_state    <= S_STOP;
                            r_var_stop <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                            r_cyc   <= '0;
                        end
                    end
                end
                S_STOP: begin
                    r_state    <= S_DONE;
                    r_var_stop <= 1'b0;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b1;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign var_init   = r_var_init;
    assign var_stop   = r_var_stop;
    assign busy       = r_busy;
    assign done       = r_done;
    assign converged  = r_converged;
    assign iter_count = r_iter_count;

endmodule

// File: tb/tb_bp_sched.sv
// Randomized bench for bp_sched against an iteration-level reference model.
module tb_bp_sched;

    localparam int NV  = 4;
    localparam int BW  = 8;
    localparam int IC  = 16;
    localparam int TH  = 2;
    localparam int IT  = IC + 1;
    localparam int BWT = NV * 2 * BW;

`ifdef BP_SCHED_CONV_DETECT_EN
    localparam bit CONV_EN = 1'b1;
`else
    localparam bit CONV_EN = 1'b0;
`endif

    logic           CLK100MHZ = 1'b0;
    logic           Reset_n   = 1'b0;
    logic           start     = 1'b0;
    logic           abort     = 1'b0;
    logic [7:0]     max_iters = 8'd0;
    logic [BWT-1:0] beliefs   = '0;
    logic           var_init;
    logic           var_stop;
    logic           busy;
    logic           done;
    logic           converged;
    logic [7:0]     iter_count;

    int vectors    = 0;
    int miscompares = 0;

    logic [BWT-1:0] vals [0:31];

    bp_sched #(
        .NUM_VARS    (NV),
        .BELIEF_W    (BW),
        .ITER_CYCLES (IC),
        .DELTA_TH    (TH)
    ) dut (
        .CLK100MHZ  (CLK100MHZ),
        .Reset_n    (Reset_n),
        .start      (start),
        .abort      (abort),
        .max_iters  (max_iters),
        .beliefs    (beliefs),
        .var_init   (var_init),
        .var_stop   (var_stop),
        .busy       (busy),
        .done       (done),
        .converged  (converged),
        .iter_count (iter_count)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    task automatic chk(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Belief vector presented during iteration k (k=0 is the pre-run snapshot reference).
    function automatic void build_vals(input int mode);
        int base [0:NV*2-1];
        for (int j = 0; j < NV*2; j++) base[j] = $urandom_range(0, 255);
        for (int k = 0; k < 32; k++) begin
            for (int j = 0; j < NV*2; j++) begin
                int v;
                case (mode)
                    0:       v = base[j];
                    1:       v = (j * 7 + 10 * k) % 256;
                    2:       v = (base[j] + $urandom_range(0, 3)) % 256;
                    default: v = $urandom_range(0, 255);
                endcase
                vals[k][j*BW +: BW] = v[7:0];
            end
        end
    endfunction

    function automatic bit settled(input int k);
        for (int j = 0; j < NV*2; j++) begin
            int a;
            int b;
            int d;
            a = int'(vals[k][j*BW +: BW]);
            b = int'(vals[k-1][j*BW +: BW]);
            d = (a > b) ? a - b : b - a;
            if (d > TH) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Cycle numbers are relative to the cycle in which start is presented.
    // Iteration k ends with its CHECK at cycle 2+IT*k.
    function automatic void model(input int mi, input int ab,
                                  output int stop, output int iters, output int conv);
        int lim;
        int t;
        lim   = (mi == 0) ? 1 : mi;
        stop  = 0;
        iters = 0;
        conv  = 0;
        for (int k = 1; k <= lim; k++) begin
            t = 2 + IT * k;
            if (ab != 0 && ab <= t) begin
                stop = ab + 1; iters = k - 1; conv = 0;
                return;
            end
            if (CONV_EN && k >= 2 && settled(k)) begin
                stop = t + 1; iters = k; conv = 1;
                return;
            end
            if (k == lim) begin
                stop = t + 1; iters = k; conv = 0;
                return;
            end
        end
    endfunction

    task automatic run_txn(input int mi, input int ab, input int mode, input bit extra);
        int stop_e, it_e, cv_e, done_e;
        int stop_r, done_r, vi, bz, dn, it_o, cv_o;
        int k;
        build_vals(mode);
        model(mi, ab, stop_e, it_e, cv_e);
        done_e = stop_e + 1;
        stop_r = -1; done_r = -1; vi = 0; bz = 0; dn = 0; it_o = -1; cv_o = -1;
        for (int r = 0; r <= done_e + 3; r++) begin
            @(posedge CLK100MHZ);
            #1;
            k = (r < 3) ? 1 : (r - 3) / IT + 1;
            if (k > 31) k = 31;
            beliefs   = vals[k];
            max_iters = (r == 0) ? mi[7:0] : 8'($urandom_range(0, 255));
            start     = (r == 0) ||
                        (extra && ((r >= 1 && r <= stop_e && $urandom_range(0, 3) == 0) || r == done_e));
            abort     = (ab != 0 && r == ab);
            @(negedge CLK100MHZ);
            if (var_init) vi++;
            if (busy) bz++;
            if (var_stop && stop_r < 0) stop_r = r;
            if (done) begin
                dn++;
                if (done_r < 0) begin
                    done_r = r;
                    it_o   = int'(iter_count);
                    cv_o   = int'(converged);
                end
            end
        end
        start = 1'b0;
        abort = 1'b0;
        chk("var_stop_cycle", stop_r, stop_e);
        chk("done_cycle", done_r, done_e);
        chk("iter_count", it_o, it_e);
        chk("converged", cv_o, cv_e);
        chk("var_init_cycles", vi, (stop_e < 3) ? stop_e - 1 : 2);
        chk("busy_cycles", bz, stop_e);
        chk("done_pulses", dn, 1);
    endtask

    task automatic mid_reset();
        int vs;
        build_vals(3);
        for (int r = 0; r < 25; r++) begin
            @(posedge CLK100MHZ);
            #1;
            beliefs   = vals[(r < 3) ? 1 : (r - 3) / IT + 1];
            max_iters = 8'd5;
            start     = (r == 0);
            @(negedge CLK100MHZ);
            if (r == 24) chk("pre_reset_iter_count", int'(iter_count), 1);
        end
        @(posedge CLK100MHZ);
        #3;
        Reset_n = 1'b0;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_iter_count", int'(iter_count), 0);
        chk("rst_var_init", int'(var_init), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_converged", int'(converged), 0);
        vs = int'(var_stop);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK100MHZ);
            vs += int'(var_stop);
        end
        chk("rst_var_stop_seen", vs, 0);
        Reset_n = 1'b1;
        @(negedge CLK100MHZ);
        chk("post_rst_busy", int'(busy), 0);
        run_txn(2, 0, 3, 1'b0);
    endtask

    initial begin
        int mi, ab, lim;
        repeat (3) @(posedge CLK100MHZ);
        @(negedge CLK100MHZ);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_var_init", int'(var_init), 0);
        chk("reset_var_stop", int'(var_stop), 0);
        chk("reset_converged", int'(converged), 0);
        chk("reset_iter_count", int'(iter_count), 0);
        Reset_n = 1'b1;

        run_txn(3, 0, 1, 1'b0);             // beliefs moving by 10 per iteration
        run_txn(20, 0, 0, 1'b0);            // constant beliefs
        run_txn(0, 0, 3, 1'b0);             // zero limit behaves as one
        run_txn(4, 3 + IT + 5, 3, 1'b0);    // abort in RUN cycle 5 of iteration 2
        run_txn(2, 0, 3, 1'b1);             // stray starts while busy and in DONE
        run_txn(2, 1, 3, 1'b0);             // abort on the first INIT cycle
        run_txn(3, 2 + IT * 2, 0, 1'b0);    // abort coinciding with a converging CHECK
        mid_reset();

        repeat (40) begin
            mi  = $urandom_range(0, 6);
            lim = (mi == 0) ? 1 : mi;
            ab  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 4 + IT * lim) : 0;
            run_txn(mi, ab, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
